gtech_rr_arb4: RTL and testbench
================================

Name: gtech_rr_arb4

Overview:
Four-requester round-robin arbiter that shares one GTECH-built resource (bus, datapath slice, memory port) between requesters 0..3.
- Registered one-hot grant with hold-while-requested and optional forced preemption after MAX_HOLD cycles.
- Mandatory one dead cycle between owners.
- Exports an all-requesters-active flag (4-input AND of requests) for congestion monitoring.

Parameters:
- CNT_W, 8: width of the hold counter; MAX_HOLD must be ≤ 2^CNT_W−1.
- MAX_HOLD, 16: max consecutive grant cycles before forced release when another requester waits; 0 = no preemption.

Ports:
- CP, input, 1: clock, rising edge.
- CD, input, 1: asynchronous active-low reset (clear).
- REQ, input, 4: request per requester; level, held until done.
- GNT, output, 4: one-hot grant, registered.
- GNT_ID, output, 2: index of current/last owner, registered.
- BUSY, output, 1: 1 while any GNT bit is set, registered.
- ALL_REQ, output, 1: combinational REQ[0]&REQ[1]&REQ[2]&REQ[3].
- PREEMPT, output, 1: registered one-cycle pulse on a forced release.

Behaviour:
- Interface: one clock CP; reset CD is asynchronous and active-low.
- Reset (CD=0, immediate): GNT=0, GNT_ID=0, BUSY=0, PREEMPT=0, state=IDLE, PTR=0, HCNT=0.
- Deassertion of CD is synchronised externally; the first arbitration is at the first CP edge with CD=1.
- Reset mid-grant drops GNT at once. PTR returns to 0.

States are IDLE and OWN.

IDLE:
- At each edge, if REQ≠0, select the winner W: first set bit searching PTR, PTR+1, … modulo 4.
- Set GNT=1<<W, GNT_ID=W, BUSY=1, HCNT=1, state→OWN.
- Latency is 1 edge from REQ sampled to GNT.
- If REQ=0, stay in IDLE with outputs unchanged except GNT=0.

OWN (owner O=GNT_ID):
- Normal release: if REQ[O]=0 at an edge, set GNT=0, BUSY=0, PTR=(O+1) mod 4, HCNT=0, state→IDLE.
- Forced release: else if MAX_HOLD≠0 and HCNT≥MAX_HOLD and (REQ & ~(1<<O))≠0, do the same as a normal release and pulse PREEMPT=1 for one cycle.
- Otherwise hold GNT. HCNT increments and saturates at 2^CNT_W−1.
- A sole requester is never preempted; the grant persists indefinitely.

Boundary conditions:
- Every release passes through IDLE, so there is always ≥1 cycle with GNT=0 between two owners (dead cycle).
- GNT_ID keeps the last owner during IDLE.
- PTR wraps from 3 to 0.
- Simultaneous owner-drop and preemption condition: counts as a normal release, so PREEMPT=0.
- Requests arriving in OWN are ignored until IDLE.
- GNT is never multi-hot. GNT is never set for a requester whose REQ was 0 at the granting edge.

Optional Feature:
- Macro: GTECH_RR_ARB4_PRIO0_EN.
- When defined:
  - Adds input PRIO0 (1 bit).
  - While PRIO0=1, IDLE arbitration grants requester 0 whenever REQ[0]=1, regardless of PTR.
  - Preemption counts REQ[0] as waiting only when PRIO0=1; other waiters never preempt requester 0 while PRIO0=1.
  - PTR update is unchanged.
- When undefined: pure round-robin; PRIO0 port absent.

Test Plan:
- Reset, then REQ=4'b1111 held → GNT=0001 one edge later. ALL_REQ=1. After MAX_HOLD=16 cycles: GNT=0000 with PREEMPT=1, then 0010. Owners cycle 0,1,2,3,0.
- REQ=0100 only, held 100 cycles → GNT=0100 for all 100 cycles. PREEMPT never asserts.
- Owner 1 drops REQ while REQ=1001 → one dead cycle, then GNT=1000 (PTR=2 skips to 3 before wrapping to 0).
- MAX_HOLD=0, REQ=0011 held 50 cycles → GNT=0001 throughout, no preemption.
- CD pulsed low mid-grant (GNT=0100) → GNT=0000 asynchronously. After release with REQ=1100, first grant is GNT=0100 (PTR=0 search).
- With GTECH_RR_ARB4_PRIO0_EN and PRIO0=1, PTR=2, REQ=0101 → GNT=0001. With PRIO0=0 → GNT=0100.

Source files
------------

// File: rtl/gtech_rr_arb4.sv
// gtech_rr_arb4: four-requester round-robin arbiter with a registered one-hot
// grant, hold-while-requested ownership, optional forced release after
// MAX_HOLD cycles, and a mandatory dead cycle between two owners.
//
// Optional build macro GTECH_RR_ARB4_PRIO0_EN adds the PRIO0 input. While it is
// high, requester 0 wins every IDLE arbitration it takes part in. Other
// waiters cannot preempt requester 0 while PRIO0 is high. REQ[0] counts as
// a preempting waiter only while PRIO0 is high.
//
// Handshake: REQ[i] is a level request held until the requester is done.
// Requester i owns the resource for every cycle in which GNT[i]=1. Dropping
// REQ[i] releases ownership at the next CP edge. A new owner is never granted
// on the edge that releases the previous one.
//
// dbg_state exposes the FSM state (0 = IDLE, 1 = OWN) for checkers.
module gtech_rr_arb4 #(
  parameter int CNT_W    = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic       CP,
  input  logic       CD,
  input  logic [3:0] REQ,
`ifdef GTECH_RR_ARB4_PRIO0_EN
  input  logic       PRIO0,
`endif
  output logic [3:0] GNT,
  output logic [1:0] GNT_ID,
  output logic       BUSY,
  output logic       ALL_REQ,
  output logic       PREEMPT,
  output logic       dbg_state
);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] MAX_HC = CNT_W'(MAX_HOLD);

  state_t           state;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] hcnt;

  logic [1:0]       win;
  logic [3:0]       win_oh;
  logic             found;
  logic [1:0]       idx;
  logic [3:0]       waiters;
  logic             hold_done;
  logic             preempt_hit;

  assign ALL_REQ   = REQ[0] & REQ[1] & REQ[2] & REQ[3];
  assign dbg_state = (state == OWN);

  // Winner: first set request searching ptr, ptr+1, ... modulo 4
  always_comb begin
    win   = 2'd0;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && REQ[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
`ifdef GTECH_RR_ARB4_PRIO0_EN
    if (PRIO0 && REQ[0]) begin
      win = 2'd0;
    end
`endif
    win_oh = 4'b0001 << win;
  end

  // Requesters other than the current owner that may force a release
  always_comb begin
    waiters = REQ & ~(4'b0001 << GNT_ID);
`ifdef GTECH_RR_ARB4_PRIO0_EN
    if (!PRIO0) begin
      waiters[0] = 1'b0;
    end
    if (PRIO0 && (GNT_ID == 2'd0)) begin
      waiters = 4'b0000;
    end
`endif
  end

  // MAX_HOLD of zero disables forced release entirely
  generate
    if (MAX_HOLD == 0) begin : g_no_hold_limit
      assign hold_done = 1'b0;
    end else begin : g_hold_limit
      assign hold_done = (hcnt >= MAX_HC);
    end
  endgenerate

  assign preempt_hit = hold_done && (waiters != 4'b0000);

  // Arbitration FSM with registered grant, owner id, busy and preempt pulse
  always_ff @(posedge CP or negedge CD) begin
    if (!CD) begin
      state   <= IDLE;
      GNT     <= 4'b0000;
      GNT_ID  <= 2'd0;
      BUSY    <= 1'b0;
      PREEMPT <= 1'b0;
      ptr     <= 2'd0;
      hcnt    <= '0;
    end else begin
      PREEMPT <= 1'b0;
      case (state)
        IDLE: begin
          if (REQ != 4'b0000) begin
            GNT    <= win_oh;
            GNT_ID <= win;
            BUSY   <= 1'b1;
            hcnt   <= CNT_W'(1);
            state  <= OWN;
          end else begin
            GNT <= 4'b0000;
          end
        end
        OWN: begin
          if (!REQ[GNT_ID] || preempt_hit) begin
            // Owner dropping its request takes precedence: no preempt pulse
            PREEMPT <= REQ[GNT_ID];
            GNT     <= 4'b0000;
            BUSY    <= 1'b0;
            ptr     <= GNT_ID + 2'd1;
            hcnt    <= '0;
            state   <= IDLE;
          end else if (hcnt != {CNT_W{1'b1}}) begin
            hcnt <= hcnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          GNT   <= 4'b0000;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gtech_rr_arb4.sv
// tb_gtech_rr_arb4: self-checking bench for gtech_rr_arb4. Instance a uses
// MAX_HOLD=16 and instance b uses MAX_HOLD=0. A behavioural arbiter model with
// integer owner, pointer and hold count supplies every expected value.
module tb_gtech_rr_arb4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_a, req_b;
  logic       prio0;
  logic [3:0] gnt_a, gnt_b;
  logic [1:0] id_a, id_b;
  logic       busy_a, busy_b, all_a, all_b, pre_a, pre_b, st_a, st_b;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  // Model state per instance: owning flag, owner, pointer, hold count, pulse
  bit m_own[2];
  int m_owner[2];
  int m_ptr[2];
  int m_hold[2];
  bit m_pre[2];
  int m_mh[2];

  gtech_rr_arb4 #(.CNT_W(8), .MAX_HOLD(16)) dut_a (
    .CP(clk), .CD(rst_n), .REQ(req_a),
`ifdef GTECH_RR_ARB4_PRIO0_EN
    .PRIO0(prio0),
`endif
    .GNT(gnt_a), .GNT_ID(id_a), .BUSY(busy_a), .ALL_REQ(all_a),
    .PREEMPT(pre_a), .dbg_state(st_a)
  );

  gtech_rr_arb4 #(.CNT_W(8), .MAX_HOLD(0)) dut_b (
    .CP(clk), .CD(rst_n), .REQ(req_b),
`ifdef GTECH_RR_ARB4_PRIO0_EN
    .PRIO0(prio0),
`endif
    .GNT(gnt_b), .GNT_ID(id_b), .BUSY(busy_b), .ALL_REQ(all_b),
    .PREEMPT(pre_b), .dbg_state(st_b)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_own[i] = 0; m_owner[i] = 0; m_ptr[i] = 0; m_hold[i] = 0; m_pre[i] = 0;
    end
  endfunction

  // One clock edge of the arbitration rules for instance i
  function automatic void model_step(input int i, input logic [3:0] r, input logic p);
    int w;
    logic [3:0] wt;
    m_pre[i] = 0;
    if (!m_own[i]) begin
      if (r != 4'b0000) begin
        w = -1;
        for (int k = 0; k < 4; k++)
          if (w < 0 && r[(m_ptr[i] + k) % 4]) w = (m_ptr[i] + k) % 4;
`ifdef GTECH_RR_ARB4_PRIO0_EN
        if (p && r[0]) w = 0;
`endif
        m_owner[i] = w; m_own[i] = 1; m_hold[i] = 1;
      end
    end else begin
      wt = r;
      wt[m_owner[i]] = 1'b0;
`ifdef GTECH_RR_ARB4_PRIO0_EN
      if (!p) wt[0] = 1'b0;
      if (p && m_owner[i] == 0) wt = 4'b0000;
`endif
      if (!r[m_owner[i]] || (m_mh[i] != 0 && m_hold[i] >= m_mh[i] && wt != 4'b0000)) begin
        m_pre[i] = r[m_owner[i]];
        m_own[i] = 0; m_ptr[i] = (m_owner[i] + 1) % 4; m_hold[i] = 0;
      end else if (m_hold[i] < 255) begin
        m_hold[i] = m_hold[i] + 1;
      end
    end
  endfunction

  // Expected {GNT, GNT_ID, BUSY, PREEMPT} for instance i
  function automatic logic [7:0] exp_pack(input int i);
    logic [3:0] g;
    g = 4'b0000;
    if (m_own[i]) g[m_owner[i]] = 1'b1;
    return {g, 2'(m_owner[i]), m_own[i], m_pre[i]};
  endfunction

  // Drive one cycle: set requests, take an edge, advance the model, settle
  task automatic tick(input logic [3:0] ra, input logic [3:0] rb);
    req_a = ra;
    req_b = rb;
    @(posedge clk);
    model_step(0, ra, prio0);
    model_step(1, rb, prio0);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req_a = 4'b0000;
    req_b = 4'b0000;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if ({gnt_a, id_a, busy_a, pre_a} !== 8'h00) begin
      n_bad++; $display("FAIL reset_a: got %b want %b", {gnt_a, id_a, busy_a, pre_a}, 8'h00);
    end
    n_cmp++;
    if ({gnt_b, id_b, busy_b, pre_b, st_a, st_b} !== 10'h000) begin
      n_bad++; $display("FAIL reset_b: got %b want 0", {gnt_b, id_b, busy_b, pre_b, st_a, st_b});
    end
  endtask

  task automatic test_rotation();
    int owners[$];
    logic [3:0] prev;
    apply_reset();
    prev = 4'b0000;
    for (int c = 1; c <= 70; c++) begin
      tick(4'b1111, 4'b0000);
      n_cmp++;
      if ({gnt_a, id_a, busy_a, pre_a} !== exp_pack(0)) begin
        n_bad++; $display("FAIL rotation c=%0d: got %b want %b", c, {gnt_a, id_a, busy_a, pre_a}, exp_pack(0));
      end
      if (gnt_a != 4'b0000 && prev == 4'b0000) owners.push_back(int'(id_a));
      prev = gnt_a;
      if (c == 1) begin
        n_cmp++;
        if (gnt_a !== 4'b0001 || all_a !== 1'b1) begin
          n_bad++; $display("FAIL first_grant: got gnt=%b all=%b want 0001 1", gnt_a, all_a);
        end
      end
      if (c == 17) begin
        n_cmp++;
        if (gnt_a !== 4'b0000 || pre_a !== 1'b1) begin
          n_bad++; $display("FAIL preempt_edge: got gnt=%b pre=%b want 0000 1", gnt_a, pre_a);
        end
      end
      if (c == 18) begin
        n_cmp++;
        if (gnt_a !== 4'b0010 || pre_a !== 1'b0) begin
          n_bad++; $display("FAIL second_owner: got gnt=%b pre=%b want 0010 0", gnt_a, pre_a);
        end
      end
    end
    n_cmp++;
    if (owners.size() < 5 || owners[0] != 0 || owners[1] != 1 || owners[2] != 2 ||
        owners[3] != 3 || owners[4] != 0) begin
      n_bad++; $display("FAIL owner_order: got %p want 0,1,2,3,0", owners);
    end
  endtask

  task automatic test_sole();
    int bad_cycles;
    apply_reset();
    bad_cycles = 0;
    for (int c = 0; c < 100; c++) begin
      tick(4'b0100, 4'b0000);
      if (gnt_a !== 4'b0100 || pre_a !== 1'b0 || {gnt_a, id_a, busy_a, pre_a} !== exp_pack(0))
        bad_cycles++;
    end
    n_cmp++;
    if (bad_cycles !== 0) begin
      n_bad++; $display("FAIL sole_hold: got %0d bad cycles want 0", bad_cycles);
    end
  endtask

  task automatic test_drop();
    apply_reset();
    tick(4'b0010, 4'b0000);
    tick(4'b1011, 4'b0000);
    tick(4'b1011, 4'b0000);
    n_cmp++;
    if (gnt_a !== 4'b0010) begin
      n_bad++; $display("FAIL drop_setup: got %b want 0010", gnt_a);
    end
    tick(4'b1001, 4'b0000);
    n_cmp++;
    if (gnt_a !== 4'b0000 || id_a !== 2'd1 || pre_a !== 1'b0) begin
      n_bad++; $display("FAIL dead_cycle: got gnt=%b id=%0d pre=%b want 0000 1 0", gnt_a, id_a, pre_a);
    end
    tick(4'b1001, 4'b0000);
    n_cmp++;
    if (gnt_a !== 4'b1000 || {gnt_a, id_a, busy_a, pre_a} !== exp_pack(0)) begin
      n_bad++; $display("FAIL after_drop: got %b want 1000", gnt_a);
    end
  endtask

  task automatic test_no_preempt();
    int bad_cycles;
    apply_reset();
    bad_cycles = 0;
    for (int c = 0; c < 50; c++) begin
      tick(4'b0000, 4'b0011);
      if (gnt_b !== 4'b0001 || pre_b !== 1'b0 || {gnt_b, id_b, busy_b, pre_b} !== exp_pack(1))
        bad_cycles++;
    end
    n_cmp++;
    if (bad_cycles !== 0) begin
      n_bad++; $display("FAIL no_preempt: got %0d bad cycles want 0", bad_cycles);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    tick(4'b0100, 4'b0000);
    tick(4'b0100, 4'b0000);
    n_cmp++;
    if (gnt_a !== 4'b0100) begin
      n_bad++; $display("FAIL async_setup: got %b want 0100", gnt_a);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({gnt_a, id_a, busy_a, pre_a} !== 8'h00) begin
      n_bad++; $display("FAIL async_clear: got %b want 00000000", {gnt_a, id_a, busy_a, pre_a});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(4'b1100, 4'b0000);
    n_cmp++;
    if (gnt_a !== 4'b0100 || {gnt_a, id_a, busy_a, pre_a} !== exp_pack(0)) begin
      n_bad++; $display("FAIL post_reset_grant: got %b want 0100", gnt_a);
    end
  endtask

  task automatic test_random();
    logic [3:0] ra, rb;
    logic [7:0] e;
    apply_reset();
    ra = 4'b0000;
    rb = 4'b0000;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 9) == 0) ra[b] = ~ra[b];
        if ($urandom_range(0, 9) == 0) rb[b] = ~rb[b];
      end
      tick(ra, rb);
      exp_q.push_back(exp_pack(0));
      exp_q.push_back(exp_pack(1));
      e = exp_q.pop_front();
      n_cmp++;
      if ({gnt_a, id_a, busy_a, pre_a} !== e || all_a !== (&ra)) begin
        n_bad++; $display("FAIL random_a c=%0d: got %b/%b want %b/%b", c, {gnt_a, id_a, busy_a, pre_a}, all_a, e, &ra);
      end
      e = exp_q.pop_front();
      n_cmp++;
      if ({gnt_b, id_b, busy_b, pre_b} !== e) begin
        n_bad++; $display("FAIL random_b c=%0d: got %b want %b", c, {gnt_b, id_b, busy_b, pre_b}, e);
      end
    end
  endtask

`ifdef GTECH_RR_ARB4_PRIO0_EN
  task automatic test_prio0();
    apply_reset();
    tick(4'b0010, 4'b0000);
    tick(4'b0000, 4'b0000);
    prio0 = 1'b1;
    tick(4'b0101, 4'b0000);
    n_cmp++;
    if (gnt_a !== 4'b0001) begin
      n_bad++; $display("FAIL prio0_on: got %b want 0001", gnt_a);
    end
    apply_reset();
    prio0 = 1'b0;
    tick(4'b0010, 4'b0000);
    tick(4'b0000, 4'b0000);
    tick(4'b0101, 4'b0000);
    n_cmp++;
    if (gnt_a !== 4'b0100) begin
      n_bad++; $display("FAIL prio0_off: got %b want 0100", gnt_a);
    end
  endtask
`endif

  initial begin
    m_mh[0] = 16;
    m_mh[1] = 0;
    prio0 = 1'b0;
    rst_n = 1'b0;
    req_a = 4'b0000;
    req_b = 4'b0000;
    test_reset();
    test_rotation();
    test_sole();
    test_drop();
    test_no_preempt();
    test_async_reset();
    test_random();
`ifdef GTECH_RR_ARB4_PRIO0_EN
    test_prio0();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
